// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy states, default widths and lane-width helper for pipe_stage_reg
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_t;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W-1:0] ZERO_W = '0;
  function automatic int lanes_w(input int n, input int w);
    return n * w;
  endfunction
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one stage storage slot (ctrl/data/opnd, plus pc/have_inst when PIPE_STAGE_TRACE_EN) with load, flush and wipe
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_DATA   = 4,
  parameter int NUM_OPND   = 2,
  parameter bit FLUSH_DATA = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic                                flush,
  input  logic                                wipe,
  input  logic [CTRL_W-1:0]                   ctrl_d,
  input  logic [lanes_w(NUM_DATA,DATA_W)-1:0] data_d,
  input  logic [lanes_w(NUM_OPND,DATA_W)-1:0] opnd_d,
`ifdef PIPE_STAGE_TRACE_EN
  input  logic [DEF_DATA_W-1:0]               pc_d,
  input  logic                                have_inst_d,
  output logic [DEF_DATA_W-1:0]               pc_q,
  output logic                                have_inst_q,
`endif
  output logic [CTRL_W-1:0]                   ctrl_q,
  output logic [lanes_w(NUM_DATA,DATA_W)-1:0] data_q,
  output logic [lanes_w(NUM_OPND,DATA_W)-1:0] opnd_q
);
  // operands survive flush but still follow a same-cycle load
  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      ctrl_q <= '0;
      data_q <= '0;
      opnd_q <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
      data_q <= FLUSH_DATA ? '0 : data_q;
      opnd_q <= load ? opnd_d : opnd_q;
    end else if (load) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      opnd_q <= opnd_d;
    end
  end
`ifdef PIPE_STAGE_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst || wipe || flush) begin
      pc_q        <= ZERO_W;
      have_inst_q <= 1'b0;
    end else if (load) begin
      pc_q        <= pc_d;
      have_inst_q <= have_inst_d;
    end
  end
`endif
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with 2-entry skid, operand forwarding and scoped flush; PIPE_STAGE_TRACE_EN adds pc/have_inst trace
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_DATA   = 4,
  parameter int NUM_OPND   = 2,
  parameter bit FLUSH_DATA = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CTRL_W-1:0]                   ctrl_i,
  input  logic [lanes_w(NUM_DATA,DATA_W)-1:0] data_i,
  input  logic [lanes_w(NUM_OPND,DATA_W)-1:0] opnd_i,
  input  logic [NUM_OPND-1:0]                 fwd_sel,
  input  logic [lanes_w(NUM_OPND,DATA_W)-1:0] fwd_data,
  input  logic                                flush,
`ifdef PIPE_STAGE_TRACE_EN
  input  logic [DEF_DATA_W-1:0]               pc_i,
  input  logic                                have_inst_i,
  output logic [DEF_DATA_W-1:0]               pc_o,
  output logic                                have_inst_o,
`endif
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CTRL_W-1:0]                   ctrl_o,
  output logic [lanes_w(NUM_DATA,DATA_W)-1:0] data_o,
  output logic [lanes_w(NUM_OPND,DATA_W)-1:0] opnd_o
);
  localparam int DW = lanes_w(NUM_DATA, DATA_W);
  localparam int OW = lanes_w(NUM_OPND, DATA_W);
  occ_t st, st_n;
  logic acc, pop, ld_main, ld_skid, from_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DW-1:0] main_data, skid_data, main_data_d;
  logic [OW-1:0] main_opnd, skid_opnd, main_opnd_d, cap_opnd;
  assign out_valid = st != ST_EMPTY;
  assign in_ready  = st != ST_FULL;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  genvar j;
  for (j = 0; j < NUM_OPND; j++) begin : g_fwd
    assign cap_opnd[j*DATA_W +: DATA_W] = fwd_sel[j] ? fwd_data[j*DATA_W +: DATA_W] : opnd_i[j*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) st <= ST_EMPTY;
    else st <= st_n;
  end
  always_comb begin
    st_n      = st;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    case (st)
      ST_EMPTY: begin
        ld_main = acc;
        st_n    = acc ? ST_ONE : ST_EMPTY;
      end
      ST_ONE: begin
        ld_main = acc & pop;
        ld_skid = acc & ~pop;
        st_n    = (acc & ~pop) ? ST_FULL : (~acc & pop) ? ST_EMPTY : ST_ONE;
      end
      ST_FULL: begin
        ld_main   = pop;
        from_skid = pop;
        st_n      = pop ? ST_ONE : ST_FULL;
      end
      default: st_n = ST_EMPTY;
    endcase
  end
  assign main_ctrl_d = from_skid ? skid_ctrl : ctrl_i;
  assign main_data_d = from_skid ? skid_data : data_i;
  assign main_opnd_d = from_skid ? skid_opnd : cap_opnd;
`ifdef PIPE_STAGE_TRACE_EN
  logic [DEF_DATA_W-1:0] main_pc, skid_pc;
  logic main_have, skid_have;
  assign pc_o        = main_pc;
  assign have_inst_o = main_have & out_valid;
`endif
  pipe_entry #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .NUM_OPND(NUM_OPND), .FLUSH_DATA(FLUSH_DATA)
  ) u_main (
    .clk(clk), .rst(rst), .load(ld_main), .flush(flush), .wipe(1'b0),
    .ctrl_d(main_ctrl_d), .data_d(main_data_d), .opnd_d(main_opnd_d),
`ifdef PIPE_STAGE_TRACE_EN
    .pc_d(from_skid ? skid_pc : pc_i), .have_inst_d(from_skid ? skid_have : have_inst_i),
    .pc_q(main_pc), .have_inst_q(main_have),
`endif
    .ctrl_q(main_ctrl), .data_q(main_data), .opnd_q(main_opnd)
  );
  // skid is wiped when it drains into main so it never holds a stale beat
  pipe_entry #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .NUM_OPND(NUM_OPND), .FLUSH_DATA(FLUSH_DATA)
  ) u_skid (
    .clk(clk), .rst(rst), .load(ld_skid), .flush(flush), .wipe(from_skid),
    .ctrl_d(ctrl_i), .data_d(data_i), .opnd_d(cap_opnd),
`ifdef PIPE_STAGE_TRACE_EN
    .pc_d(pc_i), .have_inst_d(have_inst_i),
    .pc_q(skid_pc), .have_inst_q(skid_have),
`endif
    .ctrl_q(skid_ctrl), .data_q(skid_data), .opnd_q(skid_opnd)
  );
  // a bubble must never present write enables downstream
  assign ctrl_o = out_valid ? main_ctrl : '0;
  assign data_o = main_data;
  assign opnd_o = main_opnd;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed stimulus with queue scoreboard for pipe_stage_reg (both FLUSH_DATA settings)
module tb_pipe_stage_reg;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [15:0] ctrl_i = '0;
  logic [127:0] data_i = '0;
  logic [63:0] opnd_i = '0, fwd_data = '0;
  logic [1:0] fwd_sel = '0;
  logic in_ready, out_valid, in_ready_0, out_valid_0;
  logic [15:0] ctrl_o, ctrl_o_0;
  logic [127:0] data_o, data_o_0;
  logic [63:0] opnd_o, opnd_o_0;
`ifdef PIPE_STAGE_TRACE_EN
  logic [31:0] pc_i = '0, pc_o, pc_o_0;
  logic have_inst_i = 1'b0, have_inst_o, have_inst_o_0;
`endif
  typedef struct {
    logic [15:0]  c;
    logic [127:0] d;
    logic [63:0]  o;
  } beat_t;
  beat_t exp_q[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_i(ctrl_i), .data_i(data_i), .opnd_i(opnd_i), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .flush(flush),
`ifdef PIPE_STAGE_TRACE_EN
    .pc_i(pc_i), .have_inst_i(have_inst_i), .pc_o(pc_o), .have_inst_o(have_inst_o),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_o(ctrl_o), .data_o(data_o), .opnd_o(opnd_o)
  );

  pipe_stage_reg #(.FLUSH_DATA(1'b0)) u_fd0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0),
    .ctrl_i(ctrl_i), .data_i(data_i), .opnd_i(opnd_i), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .flush(flush),
`ifdef PIPE_STAGE_TRACE_EN
    .pc_i(pc_i), .have_inst_i(have_inst_i), .pc_o(pc_o_0), .have_inst_o(have_inst_o_0),
`endif
    .out_valid(out_valid_0), .out_ready(out_ready), .ctrl_o(ctrl_o_0), .data_o(data_o_0), .opnd_o(opnd_o_0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkd(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic drive(input logic v, input logic [15:0] c, input logic [127:0] d, input logic [63:0] o,
                       input logic [1:0] fs, input logic [63:0] fd, input logic ordy, input logic fl,
                       input logic push);
    in_valid = v; ctrl_i = c; data_i = d; opnd_i = o;
    fwd_sel = fs; fwd_data = fd; out_ready = ordy; flush = fl;
    if (push) exp_q.push_back('{c, d, {fs[1] ? fd[63:32] : o[63:32], fs[0] ? fd[31:0] : o[31:0]}});
    @(posedge clk); #1;
    if (fl || rst) exp_q.delete();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, '0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [15:0] c, input logic [31:0] b, input logic ordy);
    drive(1'b1, c, mkd(b), {b + 32'h11, b + 32'h10}, 2'b00, '0, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
          else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("pop_ctrl", ctrl_o, e.c);
            chk("pop_data", data_o, e.d);
            chk("pop_opnd", opnd_o, e.o);
            chk("pop_ctrl_fd0", ctrl_o_0, e.c);
            chk("pop_data_fd0", data_o_0, e.d);
          end
        end
      end
    join_none
    // reset held with a beat offered
    drive(1'b1, 16'h7777, mkd(32'h9), '1, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h7777, mkd(32'h9), '1, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_opnd", opnd_o, 0);
    rst = 1'b0;
    beat(16'h0001, 32'h100, 1'b0);
    chk("first_latency", out_valid, 1);
    chk("first_ctrl", ctrl_o, 16'h0001);
    idle(1'b1);
    chk("first_drained", out_valid, 0);
    // streaming at full throughput
    for (int i = 0; i < 4; i++) begin
      beat(16'h00A5, 32'h1000 + i, 1'b1);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_valid", out_valid, 1);
    end
    idle(1'b1);
    chk("stream_drained", out_valid, 0);
    // back-pressure fills skid
    beat(16'h00A1, 32'h2000, 1'b0);
    chk("bp_a_ready", in_ready, 1);
    beat(16'h00B2, 32'h2100, 1'b0);
    chk("bp_b_ready", in_ready, 0);
    drive(1'b1, 16'h00C3, mkd(32'h2200), '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("bp_c_ready", in_ready, 0);
    chk("bp_head_a", ctrl_o, 16'h00A1);
    idle(1'b1);
    chk("bp_ready_back", in_ready, 1);
    chk("bp_head_b", ctrl_o, 16'h00B2);
    idle(1'b1);
    chk("bp_c_lost", out_valid, 0);
    // forwarding override only at capture
    drive(1'b1, 16'h0F0F, mkd(32'h4000), {32'h22, 32'h11}, 2'b10, {32'hBB, 32'hAA}, 1'b0, 1'b0, 1'b1);
    chk("fwd_opnd", opnd_o, {32'hBB, 32'h11});
    drive(1'b0, '0, '0, {32'h66, 32'h77}, 2'b11, {32'hCC, 32'hDD}, 1'b0, 1'b0, 1'b0);
    chk("fwd_held", opnd_o, {32'hBB, 32'h11});
    idle(1'b1);
    // flush while FULL with an incoming beat
    beat(16'h0033, 32'h3000, 1'b0);
    beat(16'h0044, 32'h3100, 1'b0);
    drive(1'b1, 16'h0055, mkd(32'h3200), '0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", ctrl_o, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_data_zero", data_o, 0);
    chk("fl_opnd_hold", opnd_o, {32'h3011, 32'h3010});
    chk("fl0_valid", out_valid_0, 0);
    chk("fl0_ctrl", ctrl_o_0, 0);
    chk("fl0_data_hold", data_o_0, mkd(32'h3000));
    chk("fl0_opnd_hold", opnd_o_0, {32'h3011, 32'h3010});
    idle(1'b1);
    chk("fl_beat_lost", out_valid, 0);
    // flush with a same-cycle accept: beat dropped but operand follows it
    drive(1'b1, 16'h0066, mkd(32'h5000), {32'h42, 32'h41}, 2'b01, {32'h99, 32'h55}, 1'b0, 1'b1, 1'b0);
    chk("flacc_valid", out_valid, 0);
    chk("flacc_opnd", opnd_o, {32'h42, 32'h55});
    chk("flacc_data_fd0", data_o_0, mkd(32'h3000));
    // flush with a same-cycle pop: head still delivered
    beat(16'h0077, 32'h6000, 1'b0);
    drive(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("flpop_valid", out_valid, 0);
    chk("flpop_ready", in_ready, 1);
    // reset mid-operation
    beat(16'h0088, 32'h7000, 1'b0);
    beat(16'h0099, 32'h7100, 1'b0);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_data", data_o, 0);
    chk("mrst_opnd", opnd_o, 0);
    idle(1'b1);
    chk("mrst_empty", out_valid, 0);
`ifdef PIPE_STAGE_TRACE_EN
    pc_i = 32'h8000_0004; have_inst_i = 1'b1;
    beat(16'h00AA, 32'h8000, 1'b0);
    chk("tr_pc", pc_o, 32'h8000_0004);
    chk("tr_have", have_inst_o, 1);
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("tr_fl_pc", pc_o, 0);
    chk("tr_fl_have", have_inst_o, 0);
    chk("tr_fl_pc_fd0", pc_o_0, 0);
`endif
    idle(1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
